// File: rtl/serial_cs_rx.sv
// Receiver for the divided-clock serial link. Synchronizes the serial clock,
// data and enable into clk, shifts in MSB-first words, and reports completed
// words on rx_valid and aborted words (enable drop, serial clock stall) on rx_err.

`ifndef CLK_CS_ENABLE
`define CLK_CS_ENABLE 1'b1
`endif

module serial_cs_rx #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk_in,
  input  logic              sdata_in,
  input  logic              cs_en,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_err,
  output logic              busy
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT);

  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;

  logic              sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic              sdata_s1_q, sdata_s2_q;
  logic              cs_en_s1_q, cs_en_s2_q;
  logic [1:0]        state_q, state_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_err_q, rx_err_d;

  logic              rise;
  logic              en;
  logic [DATA_W-1:0] shifted;

  // Identical two-flop synchronizers keep the three link signals mutually aligned;
  // the third sclk flop feeds rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_s1_q  <= 1'b0;
      sclk_s2_q  <= 1'b0;
      sclk_s3_q  <= 1'b0;
      sdata_s1_q <= 1'b0;
      sdata_s2_q <= 1'b0;
      cs_en_s1_q <= 1'b0;
      cs_en_s2_q <= 1'b0;
    end else begin
      sclk_s1_q  <= sclk_in;
      sclk_s2_q  <= sclk_s1_q;
      sclk_s3_q  <= sclk_s2_q;
      sdata_s1_q <= sdata_in;
      sdata_s2_q <= sdata_s1_q;
      cs_en_s1_q <= cs_en;
      cs_en_s2_q <= cs_en_s1_q;
    end
  end

  assign rise    = sclk_s2_q & ~sclk_s3_q;
  assign en      = (cs_en_s2_q == `CLK_CS_ENABLE);
  assign shifted = {shreg_q[DATA_W-2:0], sdata_s2_q};

  // Receive FSM: next state, shift register, counters and output pulses.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    shreg_d    = shreg_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        bit_cnt_d = '0;
        tmo_cnt_d = '0;
        if (en) begin
          state_d = StShift;
          // A rise coinciding with enable is taken as bit 0.
          if (rise) begin
            shreg_d   = shifted;
            bit_cnt_d = CntW'(1);
          end
        end
      end
      StShift: begin
        if (!en) begin
          // Enable loss wins over a same-cycle rise; only a partial word is an error.
          rx_err_d  = (bit_cnt_q != '0);
          bit_cnt_d = '0;
          tmo_cnt_d = '0;
          state_d   = StIdle;
        end else if (rise) begin
          shreg_d   = shifted;
          tmo_cnt_d = '0;
          if (bit_cnt_q == LastBit) begin
            rx_data_d  = shifted;
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end else if (bit_cnt_q != '0) begin
          // Stall watchdog only runs mid-word; idling between words is legal.
          if (tmo_cnt_q == TmoLast) begin
            rx_err_d = 1'b1;
            state_d  = StFlush;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TmoW'(1);
          end
        end
      end
      StFlush: begin
        if (!en) begin
          bit_cnt_d = '0;
          tmo_cnt_d = '0;
          state_d   = StIdle;
        end
      end
      default: begin
        bit_cnt_d = '0;
        tmo_cnt_d = '0;
        state_d   = StIdle;
      end
    endcase
  end

  // State and output registers; reset discards any partial word silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      shreg_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      shreg_q    <= shreg_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_serial_cs_rx.sv
// Scoreboard bench for serial_cs_rx: stimulus pushes expected events (kind, data,
// cycle) into a queue; a monitor pops and compares on every rx_valid/rx_err pulse.

`ifndef CLK_CS_ENABLE
`define CLK_CS_ENABLE 1'b1
`endif

module tb_serial_cs_rx;

  localparam int unsigned DataW   = 8;
  localparam int unsigned Timeout = 16;
  localparam logic        EnOn    = `CLK_CS_ENABLE;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         at;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       sdata;
  logic       cs_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_rise = 0;
  int         r_first = 0;
  logic [7:0] last_word = 8'h00;
  ev_t        exp_q[$];
  ev_t        mon_e;

  serial_cs_rx #(
    .DATA_W (DataW),
    .TIMEOUT(Timeout)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sclk_in (sclk),
    .sdata_in(sdata),
    .cs_en   (cs_en),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_err  (rx_err),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every output pulse against the head of the scoreboard.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
      mon_e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_event: got nothing by cyc %0d, expected err=%0b data=%02h at cyc %0d",
               cyc, mon_e.is_err, mon_e.data, mon_e.at);
    end
    if (!rst && (rx_valid || rx_err)) begin
      checks++;
      if (rx_valid && rx_err) begin
        errors++;
        $display("FAIL both_pulses: got valid=1 err=1 at cyc %0d, expected at most one", cyc);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got valid=%0b err=%0b data=%02h at cyc %0d, expected none",
                 rx_valid, rx_err, rx_data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.is_err != rx_err || rx_data !== mon_e.data || cyc != mon_e.at) begin
          errors++;
          $display("FAIL event: got err=%0b data=%02h cyc %0d, expected err=%0b data=%02h cyc %0d",
                   rx_err, rx_data, cyc, mon_e.is_err, mon_e.data, mon_e.at);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input bit is_err, input logic [7:0] data, input int at);
    ev_t e;
    e.is_err = is_err;
    e.data   = data;
    e.at     = at;
    exp_q.push_back(e);
  endtask

  // One serial bit: data set a full low phase before the rise, 2 clk high, 2 clk low.
  task automatic send_bit(input bit b);
    sdata = b;
    tick(2);
    sclk      = 1'b1;
    last_rise = cyc;
    tick(2);
    sclk = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[7-i]);
  endtask

  // Full word: the valid pulse is seen 3 cycles after sclk is raised for the last bit.
  task automatic send_word(input logic [7:0] w);
    send_bits(w, 8);
    push(1'b0, w, last_rise + 3);
    last_word = w;
  endtask

  initial begin
    rst   = 1'b1;
    sclk  = 1'b0;
    sdata = 1'b0;
    cs_en = ~EnOn;
    tick(2);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_rx_valid", rx_valid, 1'b0);
    chk("reset_rx_err", rx_err, 1'b0);
    chk("reset_busy", busy, 1'b0);
    rst = 1'b0;
    tick(2);

    // Single word, and busy following enable through the synchronizer.
    cs_en = EnOn;
    tick(2);
    chk("busy_before_sync", busy, 1'b0);
    tick(1);
    chk("busy_after_enable", busy, 1'b1);
    send_word(8'hA5);
    tick(4);
    cs_en = ~EnOn;
    tick(5);
    chk("busy_after_disable", busy, 1'b0);

    // Back-to-back words with no gap.
    cs_en = EnOn;
    tick(4);
    send_word(8'h3C);
    r_first = last_rise;
    send_word(8'hC3);
    chk("b2b_gap", last_rise - r_first, 32);
    tick(4);
    cs_en = ~EnOn;
    tick(5);

    // Enable drop after 5 bits: error, rx_data untouched, then recovery.
    cs_en = EnOn;
    tick(4);
    send_bits(8'hFF, 5);
    cs_en = ~EnOn;
    push(1'b1, last_word, cyc + 3);
    tick(6);
    chk("drop_rx_data_kept", rx_data, 8'hC3);
    chk("drop_busy", busy, 1'b0);
    cs_en = EnOn;
    tick(4);
    send_word(8'h12);
    tick(4);
    cs_en = ~EnOn;
    tick(5);

    // Serial clock stall after 3 bits: error TIMEOUT cycles after the last shift.
    cs_en = EnOn;
    tick(4);
    send_bits(8'h96, 3);
    push(1'b1, last_word, last_rise + 3 + Timeout);
    tick(Timeout + 4);
    chk("stall_flush_busy", busy, 1'b1);
    send_bits(8'hFF, 8);
    tick(4);
    chk("flush_still_busy", busy, 1'b1);
    cs_en = ~EnOn;
    tick(4);
    chk("flush_to_idle", busy, 1'b0);

    // Enable drop sampled at the same edge as the 8th rise: error, no valid.
    cs_en = EnOn;
    tick(4);
    send_bits(8'h77, 7);
    sdata = 1'b1;
    tick(2);
    sclk  = 1'b1;
    cs_en = ~EnOn;
    push(1'b1, last_word, cyc + 3);
    tick(2);
    sclk = 1'b0;
    tick(6);
    chk("simul_rx_data_kept", rx_data, 8'h12);

    // Asynchronous reset during bit 4, then a clean word.
    cs_en = EnOn;
    tick(4);
    send_bits(8'h5A, 4);
    sdata = 1'b1;
    tick(2);
    sclk = 1'b1;
    tick(1);
    rst   = 1'b1;
    sclk  = 1'b0;
    cs_en = ~EnOn;
    #1;
    chk("async_rst_rx_data", rx_data, 8'h00);
    chk("async_rst_rx_valid", rx_valid, 1'b0);
    chk("async_rst_rx_err", rx_err, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    tick(2);
    rst = 1'b0;
    tick(2);
    cs_en = EnOn;
    tick(4);
    send_word(8'h5A);
    tick(6);
    chk("final_rx_data", rx_data, 8'h5A);
    cs_en = ~EnOn;
    tick(6);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by time limit, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/serial_cs_rx.md
# serial_cs_rx

Receiver end of the divided-clock serial link: it samples the serial clock `clk_cs` produced by the transmitter-side divider, together with its data line. Frames are gated by the link enable. The block synchronizes all three link signals into `clk` and shifts in MSB-first words. It hands each completed word to the core as a one-cycle `rx_valid` pulse. Protocol faults (enable dropped mid-word, serial clock stall) are reported on `rx_err`, and the receiver re-arms cleanly.

## Interface
Parameters:
- `DATA_W`, default 8: word length in bits, valid range 2..16.
- `TIMEOUT`, default 16: `clk` cycles without a serial-clock rising edge, mid-word, before abort. Must be > 4; the transmitter's edge spacing is 4 `clk`.

Ports:
- `clk`, in, 1: system clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `sclk_in`, in, 1: serial clock from the transmitter's divider. Idles low.
- `sdata_in`, in, 1: serial data, stable around `sclk_in` rising edges.
- `cs_en`, in, 1: link enable. Active level is `` `CLK_CS_ENABLE`` (define.v).
- `rx_data`, out, `DATA_W`: last completed word.
- `rx_valid`, out, 1: one-cycle pulse, `rx_data` is new.
- `rx_err`, out, 1: one-cycle pulse, word aborted.
- `busy`, out, 1: high while in SHIFT or FLUSH.

## Operation
- **Synchronizers:** `sclk_in`, `sdata_in` and `cs_en` each pass through an identical 2-flop synchronizer (`*_s1`, `*_s2`), so the three signals stay mutually aligned.
- **Edge detection:** a third flop `sclk_s3` follows `sclk_s2`. `rise = sclk_s2 & ~sclk_s3`.
- **Enable qualifier:** `en = (cs_en_s2 == `CLK_CS_ENABLE)`.
- **State machine**, states IDLE, SHIFT, FLUSH:
  - IDLE: `bit_cnt` = 0, `tmo_cnt` = 0. If `en` → SHIFT. A rise in the same cycle is processed as bit 0.
  - SHIFT, processing a rise: `shreg <= {shreg[DATA_W-2:0], sdata_s2}`, `bit_cnt` +1, `tmo_cnt` cleared.
    - On the rise that completes bit `DATA_W-1`: `rx_data <= {shreg[DATA_W-2:0], sdata_s2}`, pulse `rx_valid`, `bit_cnt` → 0, remain in SHIFT.
    - Back-to-back words need no gap.
  - SHIFT, `!en`: rise is ignored. `bit_cnt` > 0 → pulse `rx_err`. `bit_cnt` == 0 → no error. Next state IDLE.
  - SHIFT, `en` and `bit_cnt` > 0 and no rise: `tmo_cnt` +1.
  - SHIFT, timeout: when `tmo_cnt` reaches `TIMEOUT-1` with no rise, pulse `rx_err` and go to FLUSH.
  - SHIFT, `bit_cnt` == 0: `tmo_cnt` holds at 0. The link may idle between words with enable active.
  - FLUSH: ignore all rises. Go to IDLE when `!en`. No further `rx_err` pulses.
- **Data width rules:**
  - `bit_cnt` is `$clog2(DATA_W+1)` bits.
  - `tmo_cnt` is `$clog2(TIMEOUT)` bits and saturates; no wrap.
  - `rx_data` is never modified by an aborted word.
- `busy = (state != IDLE)`.

## Timing
- **Reset values:**
  - `rx_data` = 0, `rx_valid` = 0, `rx_err` = 0, `busy` = 0, state IDLE.
  - All sync flops, `shreg`, `bit_cnt` and `tmo_cnt` = 0.
- **Reset mid-word:** the partial word is discarded with no `rx_err`. Outputs return to reset values immediately, asynchronously.
- **Latency:** let N be the first `clk` edge that samples `sclk_in` high. The shift occurs at edge N+2. For the last bit, `rx_data`/`rx_valid` update at N+2, and `rx_valid` is high for exactly the cycle after N+2.
- **Enable drop:** `cs_en` deassertion is acted on 2 edges after first sampled. It is simultaneous with a final-bit rise if both are first sampled at the same edge; the rise is lost, `rx_err` pulses and `rx_valid` stays low.
- **Sampling margin:** `sdata_in` must be stable from 1 `clk` before to 1 `clk` after each `sclk_in` rise.
- **Minimum serial clock:** `sclk_in` high and low phases are each ≥ 2 `clk`. The divider's 2-`clk` phase (4-`clk` period) is the minimum supported.
- `rx_valid` and `rx_err` are never high in the same cycle.

## Test plan
- **Single word:** enable active, send 0xA5 MSB-first at 4-`clk` period → one `rx_valid` pulse with `rx_data`=0xA5, `rx_err` never high, `busy` high from IDLE→SHIFT.
- **Back-to-back words:** 0x3C then 0xC3 with no idle gap → two `rx_valid` pulses exactly 32 `clk` apart, `rx_data` 0x3C then 0xC3.
- **Enable drop mid-word:** drop enable after 5 bits of 0xFF → one `rx_err` pulse, `rx_data` keeps the previous value; the next full word 0x12 is received correctly.
- **Serial clock stall:** stop `sclk_in` after 3 bits with enable held → `rx_err` pulses exactly `TIMEOUT` cycles after the last processed rise, state FLUSH. Extra rises give no `rx_valid`. IDLE follows once enable drops.
- **Simultaneous events:** enable drop first sampled at the same edge as the 8th rise → `rx_err`=1, `rx_valid`=0.
- **Async reset:** assert `rst` mid-word (bit 4) → all outputs 0 within the same cycle, no `rx_err`. After release, 0x5A is received correctly.
